btn_conditioner: RTL and testbench
==================================

// Module: btn_conditioner
// PURPOSE
//  Input conditioning stage feeding the up/down counter + 7-seg path: takes raw board
//  buttons/switches (async, bouncing) and produces clean control levels for the counter.
//  Per input: 2-FF synchroniser, then debounce filter; enable button becomes a
//  press-to-toggle level. Outputs are levels, never 1-cycle pulses, because the counter
//  samples them on the slow divided clock.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  consecutive stable clk cycles to accept a change (10 ms @ 50 MHz); legal >= 2
//  DB_W             $clog2(DEBOUNCE_CYCLES+1)  width of debounce counters (localparam, derived)
// PORTS
//  clk          in   1  system clock (undivided board clock)
//  rst          in   1  reset, asynchronous, active-high
//  btn_enable   in   1  raw push button; each accepted press toggles enable
//  btn_load     in   1  raw push button; debounced level drives load
//  sw_up_down   in   1  raw slide switch; 1 = count up, 0 = count down
//  sw_data      in   4  raw slide switches; parallel load value
//  enable       out  1  toggled run/stop level
//  load         out  1  debounced btn_load level
//  up_down      out  1  debounced sw_up_down level
//  data_in      out  4  debounced sw_data, updated atomically as a 4-bit group
//  press_evt    out  1  1-clk strobe on every accepted btn_enable rising edge (debug/LED)
// BEHAVIOUR
//  - Reset (async assert, sync release): all sync FFs, stable values, counters and all
//    outputs = 0. Reset mid-debounce discards the pending change.
//  - Sync: each raw input passes 2 FFs; raw inputs are never used past the 2nd FF.
//  - Debounce cell (1-bit and 4-bit group): holds stable value S and counter C.
//    * sync == S            -> C <= 0.
//    * sync != S, C < N-1   -> C <= C+1.
//    * sync != S, C == N-1  -> S <= sync, C <= 0.  (N = DEBOUNCE_CYCLES)
//    * Any glitch back to S before N consecutive cycles resets C; no partial acceptance.
//    * 4-bit group: a change of sync value to a different non-S value also clears C
//      (must be N cycles of one identical value); S updates all 4 bits in one cycle.
//  - Latency: raw edge held steady -> output change after exactly N+2 clk cycles
//    (2 sync + N filter); registered outputs, no combinational path from inputs.
//  - enable: on rising edge of debounced btn_enable (S 0->1) enable <= ~enable and
//    press_evt = 1 for that single cycle; release (1->0) has no effect.
//  - load, up_down, data_in: equal the respective stable value S.
//  - Simultaneous acceptances on different inputs are independent, same cycle.
//  - Counters never exceed N-1; no wrap-around possible.
// STRUCTURE
//  - Shared package btn_cond_pkg: DEFAULT_DEBOUNCE_CYCLES constant, DB_W function/const.
//  - Sub-module debounce_cell #(W, DEBOUNCE_CYCLES): 2-FF sync + filter, output S
//    and rise strobe; instantiated 4x (W=1,1,1,4). Top adds enable toggle only.
//  - Top-level wrapper instantiates btn_conditioner ahead of clkdiv/counter/decoder.
// TESTING  (bench uses DEBOUNCE_CYCLES=4)
//  1 Reset: assert rst with all inputs 1 -> all outputs 0; hold 0 while rst high.
//  2 Clean press: btn_load 0->1 held -> load rises exactly 6 clks later; release -> falls 6 clks later.
//  3 Bounce: btn_enable 1 for 3 clks, 0 for 1, then 1 steady -> single toggle (enable=1),
//    one press_evt pulse, 6 clks after final rise; second full press -> enable=0.
//  4 Group: sw_data 0000->0101 for 3 clks ->0110 steady -> data_in never shows 0101,
//    shows 0110 6 clks after 0110 applied, all bits in same cycle.
//  5 Reset mid-operation: sw_up_down 0->1, rst pulse after 3 clks -> up_down stays 0 and
//    needs a full 6 clks after release to reach 1.
//  6 Simultaneous: btn_load and sw_up_down rise same cycle -> load and up_down rise same cycle.

Source files
------------

// File: rtl/btn_cond_pkg.sv
// Shared constants and helpers for the button/switch conditioning stage.
package btn_cond_pkg;

  // 10 ms of stability at a 50 MHz board clock
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

  function automatic int db_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/btn_conditioner_debounce_cell.sv
// Two-flop synchroniser followed by a consecutive-stable-cycle filter.
// The filter accepts a new W-bit value only after N cycles of one identical value.
module debounce_cell
  import btn_cond_pkg::*;
#(
  parameter int W               = 1,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] raw,
  output logic [W-1:0] stable,
  output logic         rise
);

  localparam int DB_W = db_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]    sync_q1;
  logic [W-1:0]    sync_q2;
  logic [W-1:0]    prev_q;
  logic [DB_W-1:0] cnt;
  logic            accept;

  // prev_q holds last cycle's synchronised value so a switch between two
  // different non-stable values restarts the count at its first cycle.
  assign accept = (sync_q2 != stable) && (sync_q2 == prev_q) && (cnt == CNT_LAST);
  assign rise   = accept && sync_q2[0] && !stable[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      prev_q  <= '0;
      stable  <= '0;
      cnt     <= '0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      prev_q  <= sync_q2;
      if (sync_q2 == stable) begin
        cnt <= '0;
      end else if (sync_q2 != prev_q) begin
        cnt <= DB_W'(1);
      end else if (cnt == CNT_LAST) begin
        stable <= sync_q2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Conditions raw board buttons/switches into clean control levels for the
// up/down counter; the enable button becomes a press-to-toggle level.
module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_enable,
  input  logic       btn_load,
  input  logic       sw_up_down,
  input  logic [3:0] sw_data,
  output logic       enable,
  output logic       load,
  output logic       up_down,
  output logic [3:0] data_in,
  output logic       press_evt
);

  logic en_rise;
  logic unused_en_level;
  logic unused_load_rise;
  logic unused_ud_rise;
  logic unused_data_rise;

  debounce_cell #(.W(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enable (
    .clk    (clk),
    .rst    (rst),
    .raw    (btn_enable),
    .stable (unused_en_level),
    .rise   (en_rise)
  );

  debounce_cell #(.W(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
    .clk    (clk),
    .rst    (rst),
    .raw    (btn_load),
    .stable (load),
    .rise   (unused_load_rise)
  );

  debounce_cell #(.W(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up_down (
    .clk    (clk),
    .rst    (rst),
    .raw    (sw_up_down),
    .stable (up_down),
    .rise   (unused_ud_rise)
  );

  debounce_cell #(.W(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_data (
    .clk    (clk),
    .rst    (rst),
    .raw    (sw_data),
    .stable (data_in),
    .rise   (unused_data_rise)
  );

  // Toggle on the same edge the debounced press is accepted, so enable
  // tracks the filter latency exactly; press_evt marks that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable    <= 1'b0;
      press_evt <= 1'b0;
    end else begin
      press_evt <= en_rise;
      if (en_rise) begin
        enable <= ~enable;
      end
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Randomised and directed bench for btn_conditioner with a window-based reference model.
module tb_btn_conditioner;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_enable, btn_load, sw_up_down;
  logic [3:0] sw_data;
  logic       enable, load, up_down, press_evt;
  logic [3:0] data_in;

  btn_conditioner #(.DEBOUNCE_CYCLES(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_enable (btn_enable),
    .btn_load   (btn_load),
    .sw_up_down (sw_up_down),
    .sw_data    (sw_data),
    .enable     (enable),
    .load       (load),
    .up_down    (up_down),
    .data_in    (data_in),
    .press_evt  (press_evt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int pe_cnt  = 0;
  bit saw_0101 = 0;

  // Reference: raw history per channel; value v is accepted when the N samples
  // that reached the filter (raw taken 2..N+1 edges ago) are all v and v != stable.
  logic [3:0] hist [4][N+2];
  logic [3:0] m_s  [4];
  logic       m_en, m_pe;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 4; c++) begin
      m_s[c] = 4'd0;
      for (int k = 0; k < N + 2; k++) hist[c][k] = 4'd0;
    end
    m_en = 1'b0;
    m_pe = 1'b0;
  endtask

  task automatic model_edge();
    logic [3:0] raw_v [4];
    bit rose;
    bit same;
    if (rst) begin
      model_clear();
      return;
    end
    raw_v[0] = {3'b0, btn_enable};
    raw_v[1] = {3'b0, btn_load};
    raw_v[2] = {3'b0, sw_up_down};
    raw_v[3] = sw_data;
    rose = 0;
    for (int c = 0; c < 4; c++) begin
      for (int k = N + 1; k > 0; k--) hist[c][k] = hist[c][k-1];
      hist[c][0] = raw_v[c];
      same = 1;
      for (int k = 2; k <= N + 1; k++) if (hist[c][k] != hist[c][2]) same = 0;
      if (same && hist[c][2] != m_s[c]) begin
        if (c == 0 && hist[c][2] == 4'd1) rose = 1;
        m_s[c] = hist[c][2];
      end
    end
    m_pe = rose;
    if (rose) m_en = ~m_en;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("enable",    int'(enable),    int'(m_en));
    check("press_evt", int'(press_evt), int'(m_pe));
    check("load",      int'(load),      int'(m_s[1][0]));
    check("up_down",   int'(up_down),   int'(m_s[2][0]));
    check("data_in",   int'(data_in),   int'(m_s[3]));
    if (press_evt) pe_cnt++;
    if (data_in == 4'b0101) saw_0101 = 1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int hold [4];

  initial begin
    model_clear();
    // 1: reset with all inputs high
    btn_enable = 1; btn_load = 1; sw_up_down = 1; sw_data = 4'hF;
    rst = 1;
    #1;
    check("t1_rst_enable", int'(enable), 0);
    check("t1_rst_load",   int'(load),   0);
    check("t1_rst_ud",     int'(up_down), 0);
    check("t1_rst_data",   int'(data_in), 0);
    check("t1_rst_pe",     int'(press_evt), 0);
    @(negedge clk);
    run(3);
    check("t1_hold_all", int'({enable, load, up_down, press_evt, data_in}), 0);
    btn_enable = 0; btn_load = 0; sw_up_down = 0; sw_data = 4'h0;
    run(1);
    rst = 0;
    run(4);

    // 2: clean press and release
    btn_load = 1;
    run(N + 1);
    check("t2_load_early", int'(load), 0);
    run(1);
    check("t2_load_rise", int'(load), 1);
    btn_load = 0;
    run(N + 1);
    check("t2_load_hold", int'(load), 1);
    run(1);
    check("t2_load_fall", int'(load), 0);

    // 3: bouncing enable press then a clean second press
    pe_cnt = 0;
    btn_enable = 1; run(3);
    btn_enable = 0; run(1);
    btn_enable = 1;
    run(N + 1);
    check("t3_en_early", int'(enable), 0);
    run(1);
    check("t3_en_toggle", int'(enable), 1);
    run(4);
    check("t3_one_pulse", pe_cnt, 1);
    btn_enable = 0; run(8);
    check("t3_release_noop", int'(enable), 1);
    btn_enable = 1; run(8);
    check("t3_second_press", int'(enable), 0);
    check("t3_two_pulses", pe_cnt, 2);
    btn_enable = 0; run(8);

    // 4: group filter must not accept a transient value
    saw_0101 = 0;
    sw_data = 4'b0101; run(3);
    sw_data = 4'b0110;
    run(N + 1);
    check("t4_data_early", int'(data_in), 0);
    run(1);
    check("t4_data_0110", int'(data_in), 6);
    check("t4_no_0101", int'(saw_0101), 0);

    // 5: reset discards a pending change
    sw_up_down = 1; run(3);
    rst = 1; run(1);
    check("t5_ud_rst", int'(up_down), 0);
    rst = 0;
    run(N + 1);
    check("t5_ud_early", int'(up_down), 0);
    run(1);
    check("t5_ud_rise", int'(up_down), 1);

    // 6: simultaneous acceptance
    sw_up_down = 0; btn_load = 0; run(8);
    btn_load = 1; sw_up_down = 1;
    run(N + 1);
    check("t6_both_early", int'({load, up_down}), 0);
    run(1);
    check("t6_both_rise", int'({load, up_down}), 3);

    // Random bouncing stimulus with occasional resets
    for (int c = 0; c < 4; c++) hold[c] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 399) == 0);
      for (int c = 0; c < 4; c++) begin
        if (hold[c] == 0) begin
          hold[c] = $urandom_range(1, 2 * N);
          case (c)
            0: btn_enable = 1'($urandom);
            1: btn_load   = 1'($urandom);
            2: sw_up_down = 1'($urandom);
            default: sw_data = 4'($urandom);
          endcase
        end else begin
          hold[c]--;
        end
      end
      step();
    end
    rst = 0;
    run(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
